axis_pkt_fifo: RTL

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

---
 rtl/axis_pkt_fifo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with a registered output stage. FRAME_FIFO=0 runs cut-through
// with backpressure; FRAME_FIFO=1 stores whole packets and drops any that overflow.
module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int          FRAME_FIFO = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  status_depth,
  output logic                    status_overflow,
  output logic                    status_good_frame
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {ACCEPT, DROP} state_e;

  state_e                state_q;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DATA_WIDTH:0]   rd_word;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         fe_ptr_q, fe_ptr_d;
  logic [PW-1:0]         lim_q;
  logic [PW-1:0]         depth_q, depth_d;
  logic                  full_q, full_d;
  logic                  rdy_q;
  logic                  ovf_q;
  logic                  good_q;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  logic                  beat;
  logic                  wr_en;
  logic                  ovf_beat;
  logic                  hs;
  logic                  load;

  assign s_axis_tready     = rdy_q && ((FRAME_FIFO != 0) || !full_q);
  assign m_axis_tdata      = out_data_q;
  assign m_axis_tlast      = out_last_q;
  assign m_axis_tvalid     = out_valid_q;
  assign status_depth      = depth_q;
  assign status_overflow   = ovf_q;
  assign status_good_frame = good_q;

  assign rd_word = mem_q[fe_ptr_q[AW-1:0]];

  always_comb begin
    beat     = s_axis_tvalid && rdy_q;
    wr_en    = 1'b0;
    ovf_beat = 1'b0;
    if (FRAME_FIFO == 0) begin
      wr_en = beat && !full_q;
    end else if (state_q == ACCEPT) begin
      if (full_q) ovf_beat = beat;
      else        wr_en    = beat;
    end

    // An overflowing packet is discarded by rewinding to the last committed boundary.
    if (wr_en)         wr_ptr_d = wr_ptr_q + PW'(1);
    else if (ovf_beat) wr_ptr_d = cm_ptr_q;
    else               wr_ptr_d = wr_ptr_q;

    cm_ptr_d = (wr_en && s_axis_tlast) ? wr_ptr_q + PW'(1) : cm_ptr_q;

    // fe_ptr fetches into the output register; rd_ptr only retires on handshake,
    // so the entry held in the output stage still counts as occupied.
    hs       = out_valid_q && m_axis_tready;
    load     = (!out_valid_q || m_axis_tready) && (fe_ptr_q != lim_q);
    fe_ptr_d = fe_ptr_q + {{AW{1'b0}}, load};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, hs};

    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    depth_d  = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // lim_q delays the readable limit one cycle so a stored beat becomes visible two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      fe_ptr_q <= '0;
      lim_q    <= '0;
      depth_q  <= '0;
      full_q   <= 1'b0;
      rdy_q    <= 1'b0;
      good_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fe_ptr_q <= fe_ptr_d;
      lim_q    <= (FRAME_FIFO != 0) ? cm_ptr_q : wr_ptr_q;
      depth_q  <= depth_d;
      full_q   <= full_d;
      rdy_q    <= 1'b1;
      good_q   <= wr_en && s_axis_tlast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= rd_word[DATA_WIDTH];
      out_data_q  <= rd_word[DATA_WIDTH-1:0];
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unique case (state_q)
        ACCEPT: begin
          if (ovf_beat) begin
            if (s_axis_tlast) ovf_q   <= 1'b1;
            else              state_q <= DROP;
          end
        end
        DROP: begin
          if (beat && s_axis_tlast) begin
            ovf_q   <= 1'b1;
            state_q <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

endmodule
